// File: rtl/alk_shift_seq.sv
// Multi-cycle barrel-less shifter: loads an operand, then shifts one bit per clock
// in the latched direction and fill mode until the count runs out or an abort arrives.
module alk_shift_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic             start_h,
  input  logic             abort_h,
  input  logic             dir_shr_h,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic             sio_in_l,
  output logic [WIDTH-1:0] dout,
  output logic             sout_h,
  output logic             sio_out_h,
  output logic             busy_h,
  output logic             done_h
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FILL_LOGIC  = 2'b00,
    FILL_ARITH  = 2'b01,
    FILL_ROTATE = 2'b10,
    FILL_EXT    = 2'b11
  } fill_mode_t;

  state_t           state;
  fill_mode_t       mode_q;
  logic             dir_q;
  logic [CNT_W-1:0] cnt;

  logic             out_bit;
  logic             fill_bit;
  logic [WIDTH-1:0] shifted;
  logic             stepping;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    out_bit  = dir_q ? dout[0] : dout[WIDTH-1];
    fill_bit = 1'b0;
    case (mode_q)
      FILL_LOGIC:  fill_bit = 1'b0;
      FILL_ARITH:  fill_bit = dir_q ? dout[WIDTH-1] : 1'b0;
      FILL_ROTATE: fill_bit = out_bit;
      FILL_EXT:    fill_bit = ~sio_in_l;
      default:     fill_bit = 1'b0;
    endcase
    shifted = dir_q ? {fill_bit, dout[WIDTH-1:1]} : {dout[WIDTH-2:0], fill_bit};
  end

  assign stepping = (state == SHIFT) && (cnt != '0);

  // Reset is synchronous, so the pad output is gated directly while it is held.
  assign sio_out_h = (!reset_h && stepping) ? out_bit : 1'b0;

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      state  <= IDLE;
      mode_q <= FILL_LOGIC;
      dir_q  <= 1'b0;
      cnt    <= '0;
      dout   <= '0;
      sout_h <= 1'b0;
      busy_h <= 1'b0;
      done_h <= 1'b0;
    end else begin
      done_h <= 1'b0;
      case (state)
        IDLE: begin
          if (start_h) begin
            state  <= SHIFT;
            dout   <= din;
            cnt    <= count;
            sout_h <= 1'b0;
            dir_q  <= dir_shr_h;
            mode_q <= fill_mode_t'(mode);
            busy_h <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort_h) begin
            // Partial result stays visible; no completion pulse.
            state  <= IDLE;
            cnt    <= '0;
            busy_h <= 1'b0;
          end else if (cnt != '0) begin
            dout   <= shifted;
            sout_h <= out_bit;
            cnt    <= cnt - CNT_W'(1);
          end else begin
            state  <= IDLE;
            busy_h <= 1'b0;
            done_h <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_h <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alk_shift_seq.sv
// Directed bench for alk_shift_seq at WIDTH=32: hand-computed results for each
// fill mode and direction, plus ignored start, abort and mid-operation reset.
module tb_alk_shift_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk_h = 1'b0;
  logic             reset_h;
  logic             start_h;
  logic             abort_h;
  logic             dir_shr_h;
  logic [1:0]       mode;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] din;
  logic             sio_in_l;
  logic [WIDTH-1:0] dout;
  logic             sout_h;
  logic             sio_out_h;
  logic             busy_h;
  logic             done_h;

  int n_checks = 0;
  int n_fail   = 0;

  alk_shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_h     (clk_h),
    .reset_h   (reset_h),
    .start_h   (start_h),
    .abort_h   (abort_h),
    .dir_shr_h (dir_shr_h),
    .mode      (mode),
    .count     (count),
    .din       (din),
    .sio_in_l  (sio_in_l),
    .dout      (dout),
    .sout_h    (sout_h),
    .sio_out_h (sio_out_h),
    .busy_h    (busy_h),
    .done_h    (done_h)
  );

  always #5 clk_h = ~clk_h;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  // Drive a start for one edge (E0), then scramble dir/mode to prove they were latched.
  task automatic start_op(input logic dir, input logic [1:0] m, input int cnt_v,
                          input logic [WIDTH-1:0] d);
    start_h   = 1'b1;
    dir_shr_h = dir;
    mode      = m;
    count     = CNT_W'(cnt_v);
    din       = d;
    tick();
    start_h   = 1'b0;
    dir_shr_h = ~dir;
    mode      = ~m;
    din       = ~d;
  endtask

  // Wait (bounded) for busy to fall; report busy cycles, first and OR-ed sio_out.
  task automatic wait_done(output int busy_cycles, output logic first_sio,
                           output logic any_sio);
    busy_cycles = 0;
    first_sio   = 1'b0;
    any_sio     = 1'b0;
    while (busy_h === 1'b1 && busy_cycles < 100) begin
      if (busy_cycles == 0) first_sio = sio_out_h;
      any_sio = any_sio | sio_out_h;
      busy_cycles++;
      tick();
    end
  endtask

  initial begin
    int   bc;
    logic fs;
    logic as;

    reset_h   = 1'b1;
    start_h   = 1'b0;
    abort_h   = 1'b0;
    dir_shr_h = 1'b0;
    mode      = 2'b00;
    count     = '0;
    din       = '0;
    sio_in_l  = 1'b1;
    tick();
    tick();
    check("reset_dout", 64'(dout), 64'h0);
    check("reset_flags", {60'h0, sout_h, sio_out_h, busy_h, done_h}, 64'h0);
    reset_h = 1'b0;
    tick();
    check("idle_flags", {60'h0, sout_h, sio_out_h, busy_h, done_h}, 64'h0);

    // Left logical, 0x1 << 4.
    start_op(1'b0, 2'b00, 4, 32'h0000_0001);
    wait_done(bc, fs, as);
    check("l_log_busy_cycles", 64'(bc), 64'd5);
    check("l_log_done", 64'(done_h), 64'h1);
    check("l_log_dout", 64'(dout), 64'h0000_0010);
    check("l_log_sout", 64'(sout_h), 64'h0);
    tick();
    check("l_log_done_pulse_one_cycle", 64'(done_h), 64'h0);
    check("l_log_idle_hold", 64'(dout), 64'h0000_0010);

    // Right arithmetic, sign replicated three times.
    start_op(1'b1, 2'b01, 3, 32'h8000_0000);
    wait_done(bc, fs, as);
    check("r_ari_done", 64'(done_h), 64'h1);
    check("r_ari_dout", 64'(dout), 64'hF000_0000);
    check("r_ari_sout", 64'(sout_h), 64'h0);
    check("r_ari_sio_any", 64'(as), 64'h0);
    tick();

    // Left rotate by one.
    start_op(1'b0, 2'b10, 1, 32'h8000_0001);
    check("l_rot_sio_during_shift", 64'(sio_out_h), 64'h1);
    wait_done(bc, fs, as);
    check("l_rot_busy_cycles", 64'(bc), 64'd2);
    check("l_rot_dout", 64'(dout), 64'h0000_0003);
    check("l_rot_sout", 64'(sout_h), 64'h1);
    check("l_rot_sio_after", 64'(sio_out_h), 64'h0);
    tick();

    // Right external fill (pad low means fill 1), then a count=0 start on the done cycle.
    sio_in_l = 1'b0;
    start_op(1'b1, 2'b11, 2, 32'h0000_0000);
    wait_done(bc, fs, as);
    check("r_ext_done", 64'(done_h), 64'h1);
    check("r_ext_dout", 64'(dout), 64'hC000_0000);
    start_op(1'b1, 2'b11, 0, 32'h1234_ABCD);
    wait_done(bc, fs, as);
    check("cnt0_busy_cycles", 64'(bc), 64'd1);
    check("cnt0_done", 64'(done_h), 64'h1);
    check("cnt0_dout", 64'(dout), 64'h1234_ABCD);
    check("cnt0_sout", 64'(sout_h), 64'h0);
    sio_in_l = 1'b1;
    tick();

    // count=10 left logical: ignored restart at E3, abort sampled at E5.
    start_op(1'b0, 2'b00, 10, 32'h0000_0001);
    tick();
    tick();
    start_h = 1'b1;
    count   = CNT_W'(1);
    din     = 32'hFFFF_FFFF;
    tick();
    start_h = 1'b0;
    check("restart_ignored_busy", 64'(busy_h), 64'h1);
    check("restart_ignored_dout", 64'(dout), 64'h0000_0008);
    tick();
    abort_h = 1'b1;
    tick();
    abort_h = 1'b0;
    check("abort_flags", {62'h0, busy_h, done_h}, 64'h0);
    check("abort_dout", 64'(dout), 64'h0000_0010);
    check("abort_sio", 64'(sio_out_h), 64'h0);
    tick();
    check("abort_no_late_done", 64'(done_h), 64'h0);
    check("abort_dout_hold", 64'(dout), 64'h0000_0010);

    // Reset mid-shift, then a clean right rotate of 0xF by 4.
    start_op(1'b1, 2'b10, 8, 32'h0000_000F);
    tick();
    tick();
    reset_h = 1'b1;
    #1;
    check("reset_sio_gated", 64'(sio_out_h), 64'h0);
    tick();
    check("midrst_dout", 64'(dout), 64'h0);
    check("midrst_flags", {60'h0, sout_h, sio_out_h, busy_h, done_h}, 64'h0);
    reset_h = 1'b0;
    tick();
    check("midrst_no_done", 64'(done_h), 64'h0);
    start_op(1'b1, 2'b10, 4, 32'h0000_000F);
    wait_done(bc, fs, as);
    check("post_rst_busy_cycles", 64'(bc), 64'd5);
    check("post_rst_done", 64'(done_h), 64'h1);
    check("post_rst_dout", 64'(dout), 64'hF000_0000);
    check("post_rst_sout", 64'(sout_h), 64'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alk_shift_seq.md
ALK_SHIFT_SEQ -- requirements
Module: alk_shift_seq

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits, minimum 2.
REQ-002 Parameter CNT_W, default 5: shift count width; counts 0 to 2**CNT_W-1 are legal.
REQ-003 clk_h  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_h  input  1  synchronous, active-high reset.
REQ-005 start_h  input  1  load the operand and begin an operation; sampled only in IDLE.
REQ-006 abort_h  input  1  cancel the operation in progress.
REQ-007 dir_shr_h  input  1  shift direction: 1 = right, toward bit 0; 0 = left, toward bit WIDTH-1.
REQ-008 mode  input  2  fill mode: 00 logical (zero fill); 01 arithmetic; 10 rotate; 11 external fill from the pad.
REQ-009 count  input  CNT_W  number of one-bit shift steps.
REQ-010 din  input  WIDTH  operand.
REQ-011 sio_in_l  input  1  external shift-in pad, active low; fill bit = ~sio_in_l.
REQ-012 dout  output  WIDTH  shift register contents.
REQ-013 sout_h  output  1  registered copy of the last bit shifted out.
REQ-014 sio_out_h  output  1  combinational: the bit being shifted out in the current cycle.
REQ-015 busy_h  output  1  operation in progress.
REQ-016 done_h  output  1  one-cycle completion pulse.

Function
REQ-017 States: IDLE and SHIFT; done_h is a registered pulse, not a separate state.
REQ-018 IDLE with start_h=1 at edge E0: load dout<=din, cnt<=count, sout_h<=0, latch dir_shr_h and mode, then go to SHIFT.
REQ-019 Direction and mode are latched at E0; changes on dir_shr_h or mode during SHIFT have no effect.
REQ-020 SHIFT with cnt!=0, per edge: shift dout by exactly one bit, sout_h<=outgoing bit, cnt<=cnt-1.
REQ-021 SHIFT with cnt==0, at the edge: go to IDLE; done_h<=1 for exactly one cycle; no shift.
REQ-022 Latency: done_h is high in the cycle after edge E(count+1); count=0 gives done_h after E1 with dout=din.
REQ-023 busy_h is 1 from E0 through the edge that sets done_h; busy_h=0 whenever done_h=1.
REQ-024 Left shift: outgoing bit = dout[WIDTH-1]; incoming bit enters at dout[0].
REQ-025 Right shift: outgoing bit = dout[0]; incoming bit enters at dout[WIDTH-1].
REQ-026 Fill for mode 00: 0.
REQ-027 Fill for mode 01: right shift replicates dout[WIDTH-1]; left shift fills 0.
REQ-028 Fill for mode 10: the outgoing bit (rotate).
REQ-029 Fill for mode 11: ~sio_in_l, sampled at each shift edge.
REQ-030 sio_out_h = outgoing bit while in SHIFT with cnt!=0; 0 otherwise.
REQ-031 start_h while busy_h=1 is ignored: no reload and no restart.
REQ-032 start_h in the same cycle as done_h=1 is accepted, since the FSM is in IDLE.
REQ-033 abort_h=1 in SHIFT: at the next edge go to IDLE; cnt<=0; dout and sout_h keep their partially shifted values; done_h stays 0.
REQ-034 abort_h in IDLE has no effect; abort_h has priority over start_h in the same cycle.
REQ-035 dout holds its value in IDLE until the next accepted start_h.

Reset
REQ-036 reset_h=1 at an edge sets: state IDLE, cnt 0, dout 0, sout_h 0, done_h 0, busy_h 0.
REQ-037 Reset has priority over start_h and abort_h; reset during SHIFT discards the operation without a done_h pulse.
REQ-038 All outputs are defined from the first edge with reset_h=1; sio_out_h is 0 while in reset.

Verification (WIDTH=32)
REQ-039 Left, mode 00, din=0x00000001, count=4 -> done_h after E5, dout=0x00000010, sout_h=0, busy_h high for 5 cycles.
REQ-040 Right, mode 01, din=0x80000000, count=3 -> dout=0xF0000000, sout_h=0; sio_out_h=0 on each step.
REQ-041 Left, mode 10, din=0x80000001, count=1 -> dout=0x00000003, sout_h=1, sio_out_h=1 during the shift cycle.
REQ-042 Right, mode 11, sio_in_l=0, din=0, count=2 -> dout=0xC0000000; then count=0 with din=0x1234ABCD -> done_h after E1, dout=0x1234ABCD, sout_h=0.
REQ-043 count=10 run; pulse start_h at step 3 -> ignored; assert abort_h at step 5 -> IDLE at the next edge, no done_h, dout holds the partial result.
REQ-044 reset_h asserted mid-SHIFT -> at the next edge all outputs are 0 and state is IDLE; a new start_h then completes normally.
